// File: rtl/pooling_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pooling_pkg : shared types and sizing helpers for generic_pooling_layer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package pooling_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pool_state_e;

  // Ceiling log2; exact for powers of two such as the window side.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned count);
    return (count > 1) ? log2_ceil(count) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_window_reducer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_window_reducer : streaming sum/max reduction of one K x K window
// Revision            : 1.0
// ---------------------------------------------------------------------------
module pool_window_reducer
  import pooling_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int POOL_K = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] element_i,
  input  logic                     first_i,
  input  logic                     last_i,
  input  pool_mode_e               mode_i,
  input  logic                     hold_i,
  output logic signed [OUT_W-1:0]  result_o,
  output logic                     valid_o
);

  localparam int unsigned SHIFT = 2 * log2_ceil(POOL_K);
  localparam int          ACC_W = DATA_W + int'(SHIFT);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  w_elem_ext, w_sum, w_max, w_next, w_scaled;
  logic signed [DATA_W-1:0] w_reduced;

  // The first element restarts the window, so no separate clear cycle is needed.
  always_comb begin
    w_elem_ext = ACC_W'(element_i);
    w_sum      = first_i ? w_elem_ext : (acc_q + w_elem_ext);
    w_max      = (first_i || (w_elem_ext > acc_q)) ? w_elem_ext : acc_q;
    w_next     = (mode_i == POOL_MAX) ? w_max : w_sum;
    w_scaled   = (mode_i == POOL_MAX) ? w_next : (w_next >>> SHIFT);
    w_reduced  = w_scaled[DATA_W-1:0];
    acc_d      = hold_i ? acc_q : w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign result_o = OUT_W'(w_reduced);
  assign valid_o  = last_i & ~hold_i;

endmodule
`default_nettype wire

// File: rtl/generic_pooling_layer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// generic_pooling_layer : sequential K x K average/max pooling of a flat image
// Revision              : 1.0
// ---------------------------------------------------------------------------
module generic_pooling_layer
  import pooling_pkg::*;
#(
  parameter  int IMG_W  = 28,
  parameter  int IMG_H  = 28,
  parameter  int DATA_W = 8,
  parameter  int OUT_W  = 16,
  parameter  int POOL_K = 2,
  localparam int OUT_WD = IMG_W / POOL_K,
  localparam int OUT_HT = IMG_H / POOL_K,
  localparam int N_OUT  = OUT_WD * OUT_HT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mode,
  input  logic signed [DATA_W-1:0] img  [0:IMG_W*IMG_H-1],
  output logic                     finished_pool,
  output logic signed [OUT_W-1:0]  pool [0:N_OUT-1]
);

  localparam int KW = int'(cnt_width(POOL_K));
  localparam int XW = int'(cnt_width(OUT_WD));
  localparam int YW = int'(cnt_width(OUT_HT));
  localparam int OW = int'(cnt_width(N_OUT));
  localparam int AW = int'(cnt_width(IMG_W * IMG_H));

  localparam logic [KW-1:0] K_LAST = KW'(POOL_K - 1);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_WD - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

  pool_state_e state_q, state_d;
  pool_mode_e  mode_q, mode_d;
  logic [KW-1:0] wc_q, wc_d, wr_q, wr_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [OW-1:0] o_q, o_d;

  logic signed [OUT_W-1:0] pool_q [0:N_OUT-1];

  logic                     w_step, w_first, w_last, w_valid;
  logic [AW-1:0]            w_addr;
  logic signed [DATA_W-1:0] w_elem;
  logic signed [OUT_W-1:0]  w_result;
  int                       w_row, w_col;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wc_d    = wc_q;
    wr_d    = wr_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    o_d     = o_q;
    w_step  = (state_q == ACCUM) && enable;
    w_first = (wr_q == '0) && (wc_q == '0);
    w_last  = (wr_q == K_LAST) && (wc_q == K_LAST);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ACCUM;
          mode_d  = pool_mode_e'(mode);
          wc_d    = '0;
          wr_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
          o_d     = '0;
        end
      end
      ACCUM: begin
        if (enable) begin
          if (wc_q != K_LAST) begin
            wc_d = wc_q + KW'(1);
          end else begin
            wc_d = '0;
            if (wr_q != K_LAST) begin
              wr_d = wr_q + KW'(1);
            end else begin
              wr_d = '0;
              o_d  = o_q + OW'(1);
              if (ox_q == X_LAST) begin
                ox_d = '0;
                oy_d = oy_q + YW'(1);
              end else begin
                ox_d = ox_q + XW'(1);
              end
              if (o_q == O_LAST) state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Trailing rows/columns are never addressed because ox/oy only span full windows.
  always_comb begin
    w_row  = int'(oy_q) * POOL_K + int'(wr_q);
    w_col  = int'(ox_q) * POOL_K + int'(wc_q);
    w_addr = AW'(w_row * IMG_W + w_col);
    w_elem = img[w_addr];
  end

  pool_window_reducer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .POOL_K (POOL_K)
  ) u_reducer (
    .clk       (clk),
    .reset     (reset),
    .element_i (w_elem),
    .first_i   (w_first),
    .last_i    (w_last),
    .mode_i    (mode_q),
    .hold_i    (~w_step),
    .result_o  (w_result),
    .valid_o   (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= POOL_AVG;
      wc_q    <= '0;
      wr_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wc_q    <= wc_d;
      wr_q    <= wr_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      o_q     <= o_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) pool_q[i] <= '0;
    end else if (w_valid) begin
      pool_q[o_q] <= w_result;
    end
  end

  assign finished_pool = (state_q == DONE);
  assign pool          = pool_q;

endmodule
`default_nettype wire

// File: tb/tb_generic_pooling_layer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_generic_pooling_layer : scoreboard bench for generic_pooling_layer
// Revision                 : 1.0
// ---------------------------------------------------------------------------
module tb_generic_pooling_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, mode_a, fin_a;
  logic signed [7:0]  img_a  [0:783];
  logic signed [15:0] pool_a [0:195];

  logic rst_b, en_b, mode_b, fin_b;
  logic signed [7:0]  img_b  [0:24];
  logic signed [15:0] pool_b [0:3];

  generic_pooling_layer dut_a (
    .clk           (clk),
    .reset         (rst_a),
    .enable        (en_a),
    .mode          (mode_a),
    .img           (img_a),
    .finished_pool (fin_a),
    .pool          (pool_a)
  );

  generic_pooling_layer #(
    .IMG_W (5),
    .IMG_H (5)
  ) dut_b (
    .clk           (clk),
    .reset         (rst_b),
    .enable        (en_b),
    .mode          (mode_b),
    .img           (img_b),
    .finished_pool (fin_b),
    .pool          (pool_b)
  );

  typedef struct {
    int sel;
    int idx;
    int val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int sel, input int idx);
    if (sel == 0) return int'(img_a[idx]);
    return int'(img_b[idx]);
  endfunction

  function automatic int pool_at(input int sel, input int idx);
    if (sel == 0) return int'(pool_a[idx]);
    return int'(pool_b[idx]);
  endfunction

  function automatic logic fin(input int sel);
    return (sel == 0) ? fin_a : fin_b;
  endfunction

  function automatic int nonzero(input int sel);
    int n = 0;
    int len = (sel == 0) ? 196 : 4;
    for (int i = 0; i < len; i++) if (pool_at(sel, i) != 0) n++;
    return n;
  endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) en_a = v; else en_b = v;
  endtask

  task automatic set_mode(input int sel, input logic v);
    if (sel == 0) mode_a = v; else mode_b = v;
  endtask

  // Reference model: 2x2 windows, trailing row/column ignored, floor average.
  task automatic push_expected(input int sel, input int w, input int h, input logic m);
    for (int oy = 0; oy < h / 2; oy++) begin
      for (int ox = 0; ox < w / 2; ox++) begin
        int acc = 0;
        int mx  = -100000;
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 2; c++) begin
            int v = pix(sel, (oy * 2 + r) * w + ox * 2 + c);
            acc += v;
            if (v > mx) mx = v;
          end
        end
        sb.push_back('{sel, oy * (w / 2) + ox, m ? mx : (acc >>> 2)});
      end
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      check($sformatf("pool%0d[%0d]", e.sel, e.idx), pool_at(e.sel, e.idx), e.val);
    end
  endtask

  // Starts a run and returns cycles from the start edge to finished_pool (-1 on timeout).
  task automatic run(input int sel, input logic m, input int drop_at, output int cycles);
    int cyc = 0;
    @(negedge clk);
    set_en(sel, 1'b1);
    set_mode(sel, m);
    @(posedge clk); #1;
    cycles = -1;
    while (cyc < 2000) begin
      if (cyc == drop_at)      set_en(sel, 1'b0);
      if (cyc == drop_at + 3)  set_mode(sel, ~m);
      if (cyc == drop_at + 10) set_en(sel, 1'b1);
      @(posedge clk); #1;
      cyc++;
      if (fin(sel)) begin
        cycles = cyc;
        break;
      end
    end
  endtask

  task automatic stop(input int sel);
    set_en(sel, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 784; i++) img_a[i] = 8'($urandom_range(0, 255));
    img_a[0] = 8;   img_a[1] = 0;   img_a[28] = 0;  img_a[29] = 0;
    img_a[2] = -1;  img_a[3] = -2;  img_a[30] = 0;  img_a[31] = 0;
    img_a[4] = -5;  img_a[5] = -3;  img_a[32] = -7; img_a[33] = -128;
    img_a[6] = 0;   img_a[7] = 0;   img_a[34] = 0;  img_a[35] = 0;
    for (int i = 0; i < 25; i++) img_b[i] = 8'($urandom_range(0, 255));
    img_b[0] = 4; img_b[1] = 4; img_b[5] = 4; img_b[6] = 4;
    for (int i = 0; i < 5; i++) begin
      img_b[20 + i]  = 127;
      img_b[i*5 + 4] = 127;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0;  en_b = 1'b0;
    mode_a = 1'b0; mode_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fin_a", int'(fin_a), 0);
    check("rst_pool_a", nonzero(0), 0);
    check("rst_fin_b", int'(fin_b), 0);
    check("rst_pool_b", nonzero(1), 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Average run
    push_expected(0, 28, 28, 1'b0);
    run(0, 1'b0, -100, lat);
    check("lat_avg", lat, 784);
    check("avg_w0", int'(pool_a[0]), 2);
    check("avg_w1_floor", int'(pool_a[1]), -1);
    check("avg_w2_floor", int'(pool_a[2]), -36);
    check("avg_w3_zero", int'(pool_a[3]), 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", int'(fin_a), 1);
    stop(0);
    check("done_release", int'(fin_a), 0);
    check("pool_kept", int'(pool_a[0]), 2);

    // Max run
    push_expected(0, 28, 28, 1'b1);
    run(0, 1'b1, -100, lat);
    check("lat_max", lat, 784);
    check("max_w0", int'(pool_a[0]), 8);
    check("max_w1", int'(pool_a[1]), 0);
    check("max_w2_neg", int'(pool_a[2]), -3);
    check("max_w3_zero", int'(pool_a[3]), 0);
    drain();
    stop(0);

    // Enable dropped for 10 cycles mid-run; the mode flip during the pause must be ignored
    push_expected(0, 28, 28, 1'b0);
    run(0, 1'b0, 200, lat);
    check("lat_pause", lat, 794);
    drain();
    stop(0);

    // Reset at cycle 300 with enable still high, then a fresh run
    @(negedge clk);
    en_a = 1'b1; mode_a = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("midrst_fin", int'(fin_a), 0);
    check("midrst_pool", nonzero(0), 0);
    rst_a = 1'b0;
    push_expected(0, 28, 28, 1'b0);
    run(0, 1'b0, -100, lat);
    check("lat_after_rst", lat, 784);
    drain();
    stop(0);

    // 5x5 image: trailing row/column hold 127 and must not affect results
    push_expected(1, 5, 5, 1'b0);
    run(1, 1'b0, -100, lat);
    check("lat_5x5", lat, 16);
    check("b_avg_w0", int'(pool_b[0]), 4);
    drain();
    stop(1);
    push_expected(1, 5, 5, 1'b1);
    run(1, 1'b1, -100, lat);
    check("lat_5x5_max", lat, 16);
    check("b_max_w0", int'(pool_b[0]), 4);
    drain();
    stop(1);
    for (int i = 0; i < 5; i++) begin
      img_b[20 + i]  = -128;
      img_b[i*5 + 4] = -128;
    end
    push_expected(1, 5, 5, 1'b0);
    run(1, 1'b0, -100, lat);
    check("b_poke_w0", int'(pool_b[0]), 4);
    drain();
    stop(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
